// File: rtl/msrv32_bus_pkg.sv
// Shared definitions for the RV32 instruction-fetch bus: responder states,
// HRESP encodings, boot address and the fetch address check.
package msrv32_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1,
        ERR2
    } imem_state_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [31:0] BOOT_ADDRESS = 32'h0000_0000;

    // A fetch is bad when misaligned or when its word offset from base falls
    // outside the store; the offset wraps modulo 2^32, so addresses below
    // base land far out of range.
    function automatic logic fetch_is_bad(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth_log2
    );
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || ((off >> (depth_log2 + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/msrv32_imem_store.sv
// Word-addressed instruction store: one write port, one registered read port
// with read-before-write on collision and a synchronous clear of the read data.
module msrv32_imem_store #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  rd_en_i,
    input  logic                  rd_clr_i,
    input  logic [DEPTH_LOG2-1:0] rd_idx_i,
    output logic [31:0]           rd_data_o,
    input  logic                  wr_en_i,
    input  logic [DEPTH_LOG2-1:0] wr_idx_i,
    input  logic [31:0]           wr_data_i
);

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
    logic [31:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_idx_i] <= wr_data_i;
        end
    end

    // Output register holds between reads; srst/clear only touch this register.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_q <= '0;
        end else if (rd_clr_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/msrv32_imem_responder.sv
// AHB-lite style instruction-fetch responder: accepts a fetch address, returns
// the stored word after WAIT_STATES cycles, or a two-cycle error response.
module msrv32_imem_responder
    import msrv32_bus_pkg::*;
#(
    parameter int          DEPTH_LOG2   = 10,
    parameter logic [31:0] BASE_ADDRESS = BOOT_ADDRESS,
    parameter int          WAIT_STATES  = 0
) (
    input  logic                  ms_riscv32_mp_clk_in,
    input  logic                  ms_riscv32_mp_rst_in,
    input  logic                  imem_req_in,
    input  logic [31:0]           imem_addr_in,
    output logic [31:0]           imem_rdata_out,
    output logic                  imem_ready_out,
    output logic                  imem_resp_out,
    input  logic                  load_en_in,
    input  logic [DEPTH_LOG2-1:0] load_addr_in,
    input  logic [31:0]           load_data_in,
    output logic                  busy_out
);

    localparam int          IDX_W     = DEPTH_LOG2;
    localparam logic [3:0]  WS_RELOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    imem_state_e      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             accept;
    logic             fetch_bad;
    logic [IDX_W-1:0] fetch_idx;
    logic             rd_en;
    logic             rd_clr;
    logic [IDX_W-1:0] rd_idx;

    assign accept    = imem_ready_out && imem_req_in;
    assign fetch_bad = fetch_is_bad(imem_addr_in, BASE_ADDRESS, DEPTH_LOG2);
    assign fetch_idx = IDX_W'((imem_addr_in - BASE_ADDRESS) >> 2);

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        rd_idx         = idx_q;
        imem_ready_out = 1'b0;
        imem_resp_out  = HRESP_OKAY;

        case (state_q)
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ERR1: begin
                imem_resp_out = HRESP_ERROR;
                state_d       = ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all end a phase and may accept a new address.
                imem_ready_out = 1'b1;
                imem_resp_out  = (state_q == ERR2) ? HRESP_ERROR : HRESP_OKAY;
                state_d        = IDLE;
                if (accept) begin
                    idx_d = fetch_idx;
                    if (fetch_bad) begin
                        state_d = ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WS_RELOAD;
                    end else begin
                        state_d = DATA;
                        rd_idx  = fetch_idx;
                    end
                end
            end
        endcase

        rd_en  = (state_d == DATA);
        rd_clr = (state_d == ERR2);
    end

    assign busy_out = (state_q != IDLE);

    msrv32_imem_store #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_store (
        .clk       (ms_riscv32_mp_clk_in),
        .srst      (ms_riscv32_mp_rst_in),
        .rd_en_i   (rd_en),
        .rd_clr_i  (rd_clr),
        .rd_idx_i  (rd_idx),
        .rd_data_o (imem_rdata_out),
        .wr_en_i   (load_en_in),
        .wr_idx_i  (load_addr_in),
        .wr_data_i (load_data_in)
    );

endmodule

// File: doc/msrv32_imem_responder.md
Name: msrv32_imem_responder

Overview:
- Instruction-side bus responder (slave) for the RV32 core. It is the other end of the fetch interface driven by the program counter stage.
- Samples the fetch address in the AHB-lite address phase. Returns the instruction word in the data phase, after a programmable number of wait states.
- Drives ready back to the core; the core uses ready to advance its PC. Flags misaligned and out-of-range fetches with a two-cycle error response.
- Holds a word-addressed instruction store. A side load port fills the store for boot and testbench program loading.

Parameters:
- DEPTH_LOG2, 10: instruction store holds 2^DEPTH_LOG2 32-bit words.
- BASE_ADDRESS, 32'h00000000: byte address of word 0; equals the core boot address.
- WAIT_STATES, 0: data-phase wait cycles per access, range 0..15.

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on the rising edge.
- ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset.
- imem_req_in  input  1  fetch request (HTRANS non-idle) valid in the address phase.
- imem_addr_in  input  32  fetch byte address from the PC stage.
- imem_rdata_out  output  32  instruction word; valid when ready=1 and resp=0.
- imem_ready_out  output  1  HREADY: high ends the data phase and accepts a new address.
- imem_resp_out  output  1  HRESP: 1 = error.
- load_en_in  input  1  side-port word write enable.
- load_addr_in  input  DEPTH_LOG2  side-port word index.
- load_data_in  input  32  side-port write data.
- busy_out  output  1  high while an accepted access is not yet completed.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, imem_ready_out=1, imem_resp_out=0, imem_rdata_out=0, busy_out=0, wait counter=0, captured address=0. Store contents are not reset.
- Address accept: on a clock edge where imem_ready_out=1 and imem_req_in=1, capture imem_addr_in.
  - Accept is pipelined: the completing cycle of one access may accept the next address.
- Address checks: off = addr - BASE_ADDRESS, 32-bit, wraps modulo 2^32.
  - Error if addr[1:0] != 0.
  - Error if off[31:2] >= 2^DEPTH_LOG2.
  - Otherwise the word index is off[DEPTH_LOG2+1:2].
- State machine (states IDLE, WAIT, DATA, ERR1, ERR2):
  - IDLE: ready=1, resp=0. On an accepted, checked-good address go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else DATA. On an accepted bad address go to ERR1. With no accept, stay in IDLE.
  - WAIT: ready=0, resp=0, counter decrements. When counter=0, next state is DATA.
  - DATA: ready=1, resp=0, rdata = store[index]. A new accept in this cycle follows the IDLE accept rules; otherwise go to IDLE.
  - ERR1: ready=0, resp=1; always go to ERR2.
  - ERR2: ready=1, resp=1, rdata=0. A new accept in this cycle follows the IDLE accept rules.
- Latency: with WAIT_STATES=N, data appears N+1 cycles after the accept edge. Back-to-back throughput is 1 word per N+1 cycles.
- rdata is registered. It is loaded from the store on the edge entering DATA and holds its value until the next DATA entry. It is forced to 0 on entry to ERR2.
- Load port writes store[load_addr_in] on the edge when load_en_in=1, independent of FSM state.
  - Same-edge read and write of the same word: the read returns the old word (read-before-write).
- busy_out = 1 in WAIT, DATA, ERR1 and ERR2.
- imem_req_in is ignored while imem_ready_out=0. The address is captured once at accept; later changes on imem_addr_in have no effect on the in-flight access.
- Reset asserted mid-access (any state): the access is abandoned and the reset values are applied on that edge. No data or error is returned for the abandoned access.

Decomposition:
- Shared package msrv32_bus_pkg:
  - State encoding enum: IDLE, WAIT, DATA, ERR1, ERR2.
  - HRESP_OKAY=1'b0, HRESP_ERROR=1'b1.
  - BOOT_ADDRESS constant, shared with the PC stage.
- One natural sub-module: msrv32_imem_store. Single-clock, 1 write port, 1 synchronous read port, read-before-write on address collision.
- The FSM, address checks and wait counter stay in the top module.

Test Plan:
- WAIT_STATES=0, store[0]=32'h00000013, store[1]=32'h00100093: accept 0x0, then 0x4 back-to-back -> ready stays 1, rdata=0x00000013 on cycle 1 and 0x00100093 on cycle 2, resp=0.
- WAIT_STATES=2, accept 0x8 with store[2]=32'hDEADBEEF -> ready=0 for 2 cycles, then ready=1 with rdata=0xDEADBEEF; busy_out high for those 3 cycles.
- Accept misaligned 0x6 -> ERR1 (ready=0, resp=1), then ERR2 (ready=1, resp=1, rdata=0); a good address 0x0 accepted in ERR2 completes normally on the next cycle.
- DEPTH_LOG2=4, accept 0x40 (index 16) -> error response.
- BASE_ADDRESS=0x1000, accept 0x0FFC -> error response (wrapped offset).
- Load and read the same word on the same edge: store[3]=0x11111111, then load 0x22222222 on the accept-for-0xC edge with WAIT_STATES=0 -> rdata=0x11111111 on that access; a repeat read of 0xC returns 0x22222222.
- Reset asserted during WAIT of a 3-wait access -> next cycle: ready=1, resp=0, rdata=0, busy=0, state IDLE.
